// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg: opcodes, FSM states, writeback codes and class decode shared by the control unit
package multicycle_control_unit_pkg;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OP_OP32    = 7'b0111011;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD,
    C_STORE, C_OPIMM, C_OP, C_OPIMM32, C_OP32, C_ILLEGAL
  } cls_e;

  typedef struct packed {
    logic       alu_src_imm;
    logic       alu_a_pc;
    logic       pc_next_sel;
    logic       pc_adder_sel;
    logic [1:0] wb_sel;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
  } ctrl_t;

  function automatic cls_e classify(input logic [6:0] op);
    case (op)
      OP_LUI:     return C_LUI;
      OP_AUIPC:   return C_AUIPC;
      OP_JAL:     return C_JAL;
      OP_JALR:    return C_JALR;
      OP_BRANCH:  return C_BRANCH;
      OP_LOAD:    return C_LOAD;
      OP_STORE:   return C_STORE;
      OP_OPIMM:   return C_OPIMM;
      OP_OP:      return C_OP;
      OP_OPIMM32: return C_OPIMM32;
      OP_OP32:    return C_OP32;
      default:    return C_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: control-unit to datapath/memory signal bundle
interface multicycle_control_unit_if #(parameter int CNT_W = 64);
  logic [6:0]       opcode;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_load;
  logic             pc_load;
  logic             pc_next_sel;
  logic             pc_adder_sel;
  logic             alu_src_imm;
  logic             alu_a_pc;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic             dmem_req;
  logic             dmem_we;
  logic             fault;
  logic [CNT_W-1:0] instret;

  modport slave (
    input  opcode, imem_ready, dmem_ready,
    output imem_req, ir_load, pc_load, pc_next_sel, pc_adder_sel, alu_src_imm,
           alu_a_pc, reg_we, wb_sel, dmem_req, dmem_we, fault, instret
  );

  modport master (
    output opcode, imem_ready, dmem_ready,
    input  imem_req, ir_load, pc_load, pc_next_sel, pc_adder_sel, alu_src_imm,
           alu_a_pc, reg_we, wb_sel, dmem_req, dmem_we, fault, instret
  );
endinterface

// File: rtl/multicycle_control_unit_classifier.sv
// multicycle_control_unit_classifier: opcode -> instruction class and per-class datapath steering
module multicycle_control_unit_classifier
  import multicycle_control_unit_pkg::*;
(
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);
  cls_e cls;

  assign cls       = classify(opcode_i);
  assign illegal_o = cls == C_ILLEGAL;

  // steering bits per class; PC-relative adder base unless JALR
  always_comb begin
    ctrl_o              = '0;
    ctrl_o.pc_adder_sel = 1'b1;
    case (cls)
      C_LUI:   ctrl_o.wb_sel = WB_IMM;
      C_AUIPC: begin
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.alu_a_pc    = 1'b1;
      end
      C_JAL: begin
        ctrl_o.pc_next_sel = 1'b1;
        ctrl_o.wb_sel      = WB_PC4;
      end
      C_JALR: begin
        ctrl_o.alu_src_imm  = 1'b1;
        ctrl_o.pc_next_sel  = 1'b1;
        ctrl_o.pc_adder_sel = 1'b0;
        ctrl_o.wb_sel       = WB_PC4;
      end
      C_BRANCH: ctrl_o.is_branch = 1'b1;
      C_LOAD: begin
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.is_load     = 1'b1;
        ctrl_o.wb_sel      = WB_LOAD;
      end
      C_STORE: begin
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.is_store    = 1'b1;
      end
      C_OPIMM, C_OPIMM32: ctrl_o.alu_src_imm = 1'b1;
      default: ctrl_o.wb_sel = WB_ALU;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for one RV64I instruction at a time
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 64
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  multicycle_control_unit_if.slave bus
);
  localparam int TW = $clog2(MEM_TIMEOUT + 2);

  state_e           state_q;
  logic [TW-1:0]    wait_q;
  logic [CNT_W-1:0] instret_q;
  ctrl_t            ctrl, ctrl_q;
  logic             illegal, timeout, pc_load;
  logic             in_fetch, in_exec, in_mem, in_wb;

  multicycle_control_unit_classifier u_cls (
    .opcode_i  (bus.opcode),
    .ctrl_o    (ctrl),
    .illegal_o (illegal)
  );

  assign in_fetch = state_q == S_FETCH;
  assign in_exec  = state_q == S_EXEC;
  assign in_mem   = state_q == S_MEM;
  assign in_wb    = state_q == S_WB;
  assign timeout  = (MEM_TIMEOUT != 0) && (wait_q == TW'(MEM_TIMEOUT - 1));

  // the final cycle of every instruction is the one that loads the PC
  assign pc_load = (in_exec & ctrl_q.is_branch) | (in_mem & bus.dmem_ready & ctrl_q.is_store) | in_wb;

  // FETCH is the reset state, so its strobes are masked while reset is held
  assign bus.imem_req     = rst_ni & in_fetch;
  assign bus.ir_load      = rst_ni & in_fetch & bus.imem_ready;
  assign bus.pc_load      = pc_load;
  assign bus.pc_next_sel  = pc_load & ctrl_q.pc_next_sel;
  assign bus.pc_adder_sel = pc_load & ctrl_q.pc_adder_sel;
  assign bus.alu_src_imm  = in_exec & ctrl_q.alu_src_imm;
  assign bus.alu_a_pc     = in_exec & ctrl_q.alu_a_pc;
  assign bus.reg_we       = in_wb;
  assign bus.wb_sel       = in_wb ? ctrl_q.wb_sel : WB_ALU;
  assign bus.dmem_req     = in_mem;
  assign bus.dmem_we      = in_mem & ctrl_q.is_store;
  assign bus.fault        = state_q == S_FAULT;
  assign bus.instret      = instret_q;

  // sequence one instruction, retire on PC load; FAULT absorbs until reset
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      ctrl_q    <= '0;
    end else begin
      instret_q <= instret_q + CNT_W'(pc_load);
      case (state_q)
        S_FETCH:
          if (bus.imem_ready) state_q <= S_DECODE;
          else if (timeout) state_q <= S_FAULT;
          else wait_q <= wait_q + TW'(1);
        S_DECODE: begin
          ctrl_q  <= ctrl;
          wait_q  <= '0;
          state_q <= illegal ? S_FAULT : S_EXEC;
        end
        S_EXEC: begin
          wait_q  <= '0;
          state_q <= ctrl_q.is_branch ? S_FETCH : (ctrl_q.is_load | ctrl_q.is_store) ? S_MEM : S_WB;
        end
        S_MEM:
          if (bus.dmem_ready) begin
            wait_q  <= '0;
            state_q <= ctrl_q.is_store ? S_FETCH : S_WB;
          end else if (timeout) state_q <= S_FAULT;
          else wait_q <= wait_q + TW'(1);
        S_WB: begin
          wait_q  <= '0;
          state_q <= S_FETCH;
        end
        default: state_q <= S_FAULT;
      endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized trace-based check of the multicycle control unit
module tb_multicycle_control_unit;
  localparam int TO = 16;
  localparam logic [12:0] B_IMR = 13'h1000, B_IRL = 13'h0800, B_PCL = 13'h0400, B_NXT = 13'h0200;
  localparam logic [12:0] B_ADD = 13'h0100, B_IMM = 13'h0080, B_APC = 13'h0040, B_RWE = 13'h0020;
  localparam logic [12:0] B_WB  = 13'h0018, B_DRQ = 13'h0004, B_DWE = 13'h0002, B_FLT = 13'h0001;
  localparam logic [12:0] SMSK  = B_IMR | B_IRL | B_PCL | B_RWE | B_DRQ | B_DWE | B_FLT;
  localparam logic [2:0]  K_WB = 3'd0, K_BR = 3'd1, K_LD = 3'd2, K_ST = 3'd3, K_ILL = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic       alu_chk, imm, apc, jmp, jalr;
    logic [1:0] wb;
  } cls_t;

  typedef struct {
    string       tag;
    logic [6:0]  op;
    logic        imr, dmr;
    logic [12:0] e, m;
    logic [63:0] ret;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n;
  step_t       tr[$];
  logic [63:0] retired;
  int          n_chk = 0, n_pass = 0;
  logic [6:0]  legal [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0111011};

  multicycle_control_unit_if #(.CNT_W(64)) bus ();
  multicycle_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(64)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [12:0] obs();
    return {bus.imem_req, bus.ir_load, bus.pc_load, bus.pc_next_sel, bus.pc_adder_sel,
            bus.alu_src_imm, bus.alu_a_pc, bus.reg_we, bus.wb_sel, bus.dmem_req, bus.dmem_we, bus.fault};
  endfunction

  // RISC-V semantics: which operands the ALU takes, where writeback comes from, how PC moves
  function automatic cls_t cls(input logic [6:0] op);
    case (op)
      7'b0110111: return {K_WB, 5'b00000, 2'b11};
      7'b0010111: return {K_WB, 5'b11100, 2'b00};
      7'b1101111: return {K_WB, 5'b00010, 2'b10};
      7'b1100111: return {K_WB, 5'b11011, 2'b10};
      7'b1100011: return {K_BR, 5'b10000, 2'b00};
      7'b0000011: return {K_LD, 5'b11000, 2'b01};
      7'b0100011: return {K_ST, 5'b11000, 2'b00};
      7'b0010011, 7'b0011011: return {K_WB, 5'b11000, 2'b00};
      7'b0110011, 7'b0111011: return {K_WB, 5'b10000, 2'b00};
      default:    return {K_ILL, 5'b00000, 2'b00};
    endcase
  endfunction

  function automatic logic r();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input string tag, input logic [6:0] op, input logic imr, input logic dmr,
                      input logic [12:0] e, input logic [12:0] m);
    tr.push_back('{tag, op, imr, dmr, e, m, retired});
  endtask

  task automatic fault_tail();
    repeat (4) push("fault", 7'($urandom), r(), r(), B_FLT, SMSK);
  endtask

  // expected per-cycle trace of one instruction: df fetch wait cycles, dm memory wait cycles
  task automatic gen(input logic [6:0] op, input int df, input int dm);
    cls_t        c;
    logic [12:0] e, m;
    c = cls(op);
    for (int i = 0; i < df && i < TO; i++) push("fetch_wait", 7'($urandom), 1'b0, r(), B_IMR, SMSK);
    if (df >= TO) begin
      fault_tail();
      return;
    end
    push("fetch", 7'($urandom), 1'b1, r(), B_IMR | B_IRL, SMSK);
    push("decode", op, r(), r(), 13'h0, SMSK);
    if (c.kind == K_ILL) begin
      fault_tail();
      return;
    end
    e = (c.imm ? B_IMM : 13'h0) | (c.apc ? B_APC : 13'h0);
    m = SMSK | (c.alu_chk ? (B_IMM | B_APC) : 13'h0);
    if (c.kind == K_BR) begin
      push("branch_exec", op, r(), r(), e | B_PCL | B_ADD, m | B_NXT | B_ADD);
      retired++;
      return;
    end
    push("exec", op, r(), r(), e, m);
    if (c.kind == K_LD || c.kind == K_ST) begin
      for (int i = 0; i < dm && i < TO; i++)
        push("mem_wait", op, r(), 1'b0, B_DRQ | (c.kind == K_ST ? B_DWE : 13'h0), SMSK);
      if (dm >= TO) begin
        fault_tail();
        return;
      end
      if (c.kind == K_ST) begin
        push("store_mem", op, r(), 1'b1, B_DRQ | B_DWE | B_PCL | B_ADD, SMSK | B_NXT | B_ADD);
        retired++;
        return;
      end
      push("load_mem", op, r(), 1'b1, B_DRQ, SMSK);
    end
    push("wb", op, r(), r(), B_RWE | B_PCL | {8'b0, c.wb, 3'b0} | (c.jmp ? B_NXT : 13'h0) | (c.jalr ? 13'h0 : B_ADD),
         SMSK | B_NXT | B_ADD | B_WB);
    retired++;
  endtask

  task automatic run_trace();
    step_t s;
    while (tr.size() > 0) begin
      s = tr.pop_front();
      bus.opcode     = s.op;
      bus.imem_ready = s.imr;
      bus.dmem_ready = s.dmr;
      @(negedge clk);
      chk({s.tag, "_ctl"}, 64'(obs() & s.m), 64'(s.e & s.m));
      chk({s.tag, "_instret"}, bus.instret, s.ret);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    #1;
    chk("reset_ctl", 64'(obs() & SMSK), 64'h0);
    chk("reset_instret", bus.instret, 64'h0);
    retired = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b1;
    retired        = '0;
    bus.opcode     = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    #3;
    do_reset();
    gen(7'b0010011, 0, 0);
    gen(7'b1100011, 0, 0);
    gen(7'b1100011, 2, 0);
    gen(7'b1100111, 0, 0);
    gen(7'b1101111, 1, 0);
    gen(7'b0110111, 0, 0);
    gen(7'b0010111, 0, 0);
    gen(7'b0000011, 0, 3);
    gen(7'b0100011, 0, 0);
    gen(7'b0100011, 1, 2);
    gen(7'b0010011, TO - 1, 0);
    gen(7'b0000011, 0, TO - 1);
    run_trace();
    repeat (40) gen(legal[$urandom_range(0, 9)], $urandom_range(0, 4), $urandom_range(0, 4));
    run_trace();
    gen(7'b0110011, 0, 0);
    gen(7'b1111111, 0, 0);
    run_trace();
    do_reset();
    gen(7'b0010011, TO, 0);
    run_trace();
    do_reset();
    gen(7'b0010011, 0, 0);
    gen(7'b0000011, 0, TO);
    run_trace();
    do_reset();
    gen(7'b0010011, 0, 0);
    gen(7'b0110011, 0, 0);
    gen(7'b0000011, 0, 10);
    while (tr.size() > 13) void'(tr.pop_back());
    run_trace();
    bus.dmem_ready = 1'b0;
    do_reset();
    repeat (10) gen(legal[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3));
    run_trace();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
